// File: rtl/puf_pkg.sv
// Shared definitions for the arbiter-PUF evaluation sequencer: FSM states,
// LFSR feedback taps and the substitute seed used when a zero seed is given.
package puf_pkg;

  localparam int CHAL_W_DEFAULT = 16;

  // Feedback from bits 15, 13, 12 and 10.
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    LAUNCH = 3'd2,
    SAMPLE = 3'd3,
    OUTPUT = 3'd4,
    FIN    = 3'd5
  } state_t;

  function automatic logic [15:0] lfsr_advance(input logic [15:0] value);
    return {value[14:0], ^(value & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/puf_lfsr16.sv
// 16-bit Fibonacci LFSR that produces PUF challenges. A zero seed would lock
// the register, so it is swapped for the default seed on load.
module puf_lfsr16
  import puf_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic        clear,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg <= '0;
    end else if (load) begin
      q_reg <= (seed == 16'h0000) ? DEFAULT_SEED : seed;
    end else if (step) begin
      q_reg <= lfsr_advance(q_reg);
    end else if (clear) begin
      q_reg <= '0;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/puf_eval_sequencer.sv
// Drives an arbiter PUF through clear/launch/sample cycles for each LFSR
// challenge, majority-votes repeated evaluations and streams out the results.
module puf_eval_sequencer
  import puf_pkg::*;
#(
  parameter int CHAL_W        = CHAL_W_DEFAULT,
  parameter int RESET_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int VOTES         = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       seed,
  input  logic [7:0]        num_chal,
  output logic [0:CHAL_W-1] challenge,
  output logic              puf_reset,
  output logic              puf_in,
  input  logic              puf_out,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_bit,
  output logic [0:CHAL_W-1] resp_chal,
  output logic [3:0]        resp_ones,
  output logic              busy,
  output logic              done
);

  localparam logic [7:0] CLEAR_LAST  = 8'(RESET_CYCLES - 1);
  localparam logic [7:0] LAUNCH_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0] VOTES_L     = 4'(VOTES);
  localparam logic [3:0] HALF_VOTES  = 4'(VOTES / 2);

  state_t      state_reg, state_next;
  logic [7:0]  timer_reg, timer_next;
  logic [3:0]  vote_reg, vote_next;
  logic [3:0]  ones_reg, ones_next;
  logic [7:0]  chal_cnt_reg, chal_cnt_next;
  logic [7:0]  num_reg, num_next;
  logic [1:0]  sync_reg;
  logic        lfsr_load, lfsr_step, lfsr_clear;
  logic [15:0] lfsr_q;

  logic              puf_reset_reg, puf_in_reg, busy_reg, done_reg;
  logic              resp_valid_reg, resp_bit_reg;
  logic [3:0]        resp_ones_reg;
  logic [0:CHAL_W-1] resp_chal_reg;

  puf_lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .clear (lfsr_clear),
    .seed  (seed),
    .q     (lfsr_q)
  );

  // challenge[i] = lfsr[15-i] falls out of the ascending port range.
  assign challenge = lfsr_q[CHAL_W-1:0];

  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg;
    vote_next     = vote_reg;
    ones_next     = ones_reg;
    chal_cnt_next = chal_cnt_reg;
    num_next      = num_reg;
    lfsr_load     = 1'b0;
    lfsr_step     = 1'b0;
    lfsr_clear    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          lfsr_load     = 1'b1;
          num_next      = num_chal;
          chal_cnt_next = '0;
          vote_next     = '0;
          ones_next     = '0;
          timer_next    = '0;
          state_next    = (num_chal == 8'd0) ? FIN : CLEAR;
        end
      end
      CLEAR: begin
        if (timer_reg == CLEAR_LAST) begin
          timer_next = '0;
          state_next = LAUNCH;
        end else begin
          timer_next = timer_reg + 8'd1;
        end
      end
      LAUNCH: begin
        if (timer_reg == LAUNCH_LAST) begin
          timer_next = '0;
          state_next = SAMPLE;
        end else begin
          timer_next = timer_reg + 8'd1;
        end
      end
      SAMPLE: begin
        ones_next  = ones_reg + {3'b000, sync_reg[1]};
        vote_next  = vote_reg + 4'd1;
        state_next = (vote_next < VOTES_L) ? CLEAR : OUTPUT;
      end
      OUTPUT: begin
        if (resp_ready) begin
          chal_cnt_next = chal_cnt_reg + 8'd1;
          if (chal_cnt_next == num_reg) begin
            state_next = FIN;
          end else begin
            lfsr_step  = 1'b1;
            vote_next  = '0;
            ones_next  = '0;
            state_next = CLEAR;
          end
        end
      end
      FIN: begin
        lfsr_clear = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      timer_reg      <= '0;
      vote_reg       <= '0;
      ones_reg       <= '0;
      chal_cnt_reg   <= '0;
      num_reg        <= '0;
      sync_reg       <= '0;
      puf_reset_reg  <= 1'b0;
      puf_in_reg     <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_bit_reg   <= 1'b0;
      resp_ones_reg  <= '0;
      resp_chal_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      vote_reg      <= vote_next;
      ones_reg      <= ones_next;
      chal_cnt_reg  <= chal_cnt_next;
      num_reg       <= num_next;
      sync_reg      <= {sync_reg[0], puf_out};
      puf_reset_reg <= (state_next == CLEAR);
      puf_in_reg    <= (state_next == LAUNCH) || (state_next == SAMPLE);
      busy_reg      <= (state_next != IDLE);
      done_reg      <= (state_next == FIN);
      if (state_next == OUTPUT) begin
        resp_valid_reg <= 1'b1;
        if (state_reg == SAMPLE) begin
          resp_bit_reg  <= (ones_next > HALF_VOTES);
          resp_ones_reg <= ones_next;
          resp_chal_reg <= challenge;
        end
      end else begin
        resp_valid_reg <= 1'b0;
        resp_bit_reg   <= 1'b0;
        resp_ones_reg  <= '0;
        resp_chal_reg  <= '0;
      end
    end
  end

  assign puf_reset  = puf_reset_reg;
  assign puf_in     = puf_in_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_bit   = resp_bit_reg;
  assign resp_ones  = resp_ones_reg;
  assign resp_chal  = resp_chal_reg;

endmodule

// File: tb/tb_puf_eval_sequencer.sv
// Self-checking bench for puf_eval_sequencer: a behavioural PUF supplies
// per-evaluation response bits and a reference model predicts every pair.
module tb_puf_eval_sequencer;

  localparam int R    = 2;
  localparam int S    = 4;
  localparam int V    = 3;
  localparam int EVAL = R + S + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] seed = '0;
  logic [7:0]  num_chal = '0;
  logic        puf_out = 1'b0;
  logic        resp_ready = 1'b0;
  logic [0:15] challenge, resp_chal;
  logic        puf_reset, puf_in, resp_valid, resp_bit, busy, done;
  logic [3:0]  resp_ones;

  int checks = 0;
  int errors = 0;

  bit   vote_bits [0:4095];
  int   eval_count = 0;
  int   launch_count = 0;
  int   done_count = 0;
  logic last_pr = 1'b0;
  logic last_pi = 1'b0;

  always #5 clk = ~clk;

  puf_eval_sequencer #(
    .CHAL_W(16), .RESET_CYCLES(R), .SETTLE_CYCLES(S), .VOTES(V)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed), .num_chal(num_chal),
    .challenge(challenge), .puf_reset(puf_reset), .puf_in(puf_in), .puf_out(puf_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_bit(resp_bit),
    .resp_chal(resp_chal), .resp_ones(resp_ones), .busy(busy), .done(done)
  );

  // Behavioural PUF: each new arbiter clear starts a fresh evaluation whose
  // response bit comes from the vote_bits table.
  always @(negedge clk) begin
    if (puf_reset === 1'b1 && last_pr === 1'b0) begin
      puf_out = vote_bits[eval_count % 4096];
      eval_count++;
    end
    if (puf_in === 1'b1 && last_pi === 1'b0) launch_count++;
    if (done === 1'b1) done_count++;
    last_pr = puf_reset;
    last_pi = puf_in;
  end

  function automatic logic [15:0] model_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [0:15] to_chal(input logic [15:0] l);
    logic [0:15] c;
    for (int i = 0; i < 16; i++) c[i] = l[15 - i];
    return c;
  endfunction

  task automatic run_case(input logic [15:0] s, input int n, input bit fixed_mode,
                          input logic [2:0] fixed, input int min_hold, input int max_hold,
                          input bit poke_busy, input bit poke_fin);
    logic [15:0] l;
    logic [0:15] exp_c;
    int base, ones, cyc, waited, hold, d0, l0, trace_err, pr_cycles, pi_cycles;
    bit exp_bit;
    l = (s == 16'h0000) ? 16'hACE1 : s;
    base = eval_count;
    d0 = done_count;
    for (int j = 0; j < n; j++)
      for (int v = 0; v < V; v++)
        vote_bits[(base + j * V + v) % 4096] = fixed_mode ? fixed[v] : 1'($urandom_range(0, 1));
    @(negedge clk);
    seed = s; num_chal = 8'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    for (int j = 0; j < n; j++) begin
      ones = 0;
      for (int v = 0; v < V; v++) ones += int'(vote_bits[(base + j * V + v) % 4096]);
      exp_bit = (ones > V / 2);
      exp_c = to_chal(l);
      resp_ready = (max_hold == 0) && ($urandom_range(0, 1) == 1);
      waited = 0; trace_err = 0; pr_cycles = 0; pi_cycles = 0;
      while (resp_valid !== 1'b1 && waited < 400) begin
        if (j == 0) begin
          if (puf_reset !== (((cyc - 1) % EVAL) < R)) trace_err++;
          if (puf_in !== (((cyc - 1) % EVAL) >= R)) trace_err++;
          pr_cycles += int'(puf_reset === 1'b1);
          pi_cycles += int'(puf_in === 1'b1);
          if (poke_busy && cyc == 3) begin
            start = 1'b1; seed = ~s; num_chal = 8'(n + 3);
          end else begin
            start = 1'b0;
          end
        end
        @(negedge clk);
        cyc++; waited++;
      end
      checks++;
      if (waited >= 400) begin
        errors++;
        $display("FAIL resp_valid_timeout chal=%0d waited=%0d required<400", j, waited);
        resp_ready = 1'b0;
        return;
      end
      if (j == 0) begin
        checks++;
        if (cyc !== V * EVAL + 1) begin
          errors++; $display("FAIL first_valid_latency got=%0d exp=%0d", cyc, V * EVAL + 1);
        end
        checks++;
        if (trace_err !== 0 || pr_cycles !== V * R || pi_cycles !== V * (S + 1)) begin
          errors++;
          $display("FAIL eval_trace mismatches=%0d reset_cycles=%0d exp=%0d launch_cycles=%0d exp=%0d",
                   trace_err, pr_cycles, V * R, pi_cycles, V * (S + 1));
        end
      end
      checks++;
      if (resp_bit !== exp_bit || resp_ones !== 4'(ones)) begin
        errors++;
        $display("FAIL resp_vote bit=%b exp=%b ones=%0d exp=%0d", resp_bit, exp_bit, resp_ones, ones);
      end
      checks++;
      if (resp_chal !== exp_c || challenge !== exp_c) begin
        errors++;
        $display("FAIL resp_chal got=%h challenge=%h exp=%h", resp_chal, challenge, exp_c);
      end
      $display("pair %0d seed=%h chal=%h bit=%b ones=%0d", j, s, resp_chal, resp_bit, resp_ones);
      hold = (max_hold > 0) ? int'($urandom_range(min_hold, max_hold)) : 0;
      l0 = launch_count;
      for (int h = 0; h < hold; h++) begin
        resp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({resp_valid, resp_bit, resp_ones, resp_chal, challenge} !== {1'b1, exp_bit, 4'(ones), exp_c, exp_c}) begin
          errors++;
          $display("FAIL backpressure_hold cycle=%0d valid=%b bit=%b ones=%0d chal=%h challenge=%h exp_chal=%h",
                   h, resp_valid, resp_bit, resp_ones, resp_chal, challenge, exp_c);
        end
      end
      if (hold > 0) begin
        checks++;
        if (launch_count !== l0) begin
          errors++; $display("FAIL backpressure_launches got=%0d exp=%0d", launch_count, l0);
        end
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      if (j < n - 1) begin
        l = model_next(l);
        checks++;
        if ({resp_valid, puf_reset, challenge} !== {1'b0, 1'b1, to_chal(l)}) begin
          errors++;
          $display("FAIL next_challenge valid=%b puf_reset=%b challenge=%h exp=%h",
                   resp_valid, puf_reset, challenge, to_chal(l));
        end
      end else begin
        checks++;
        if (done !== 1'b1 || resp_valid !== 1'b0) begin
          errors++; $display("FAIL done_pulse done=%b valid=%b exp done=1 valid=0", done, resp_valid);
        end
        if (poke_fin) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({done, busy} !== 2'b00 || done_count !== d0 + 1) begin
          errors++;
          $display("FAIL run_end done=%b busy=%b done_pulses=%0d exp done=0 busy=0 pulses=1",
                   done, busy, done_count - d0);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({puf_reset, puf_in, resp_valid, resp_bit, busy, done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=000000", {puf_reset, puf_in, resp_valid, resp_bit, busy, done});
    end
    checks++;
    if (challenge !== 16'h0 || resp_chal !== 16'h0 || resp_ones !== 4'h0) begin
      errors++;
      $display("FAIL reset_data challenge=%h resp_chal=%h ones=%0d exp 0", challenge, resp_chal, resp_ones);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset busy=%b exp=0", busy);
    end
  endtask

  task automatic test_basic();
    run_case(16'h0001, 2, 1'b1, 3'b111, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_noisy();
    run_case(16'h1234, 1, 1'b1, 3'b101, 0, 0, 1'b0, 1'b0);
    run_case(16'h4321, 1, 1'b1, 3'b010, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_case(16'hBEEF, 2, 1'b0, 3'b000, 10, 10, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++)
      run_case(16'($urandom), int'($urandom_range(1, 4)), 1'b0, 3'b000, 0, 3, 1'b0, 1'b0);
  endtask

  task automatic test_edge_cases();
    int d0, l0;
    d0 = done_count; l0 = launch_count;
    @(negedge clk);
    seed = 16'h5555; num_chal = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({done, busy, puf_in, puf_reset} !== 4'b1100) begin
      errors++;
      $display("FAIL zero_chal_fin done=%b busy=%b puf_in=%b puf_reset=%b exp 1100", done, busy, puf_in, puf_reset);
    end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00 || launch_count !== l0 || done_count !== d0 + 1) begin
      errors++;
      $display("FAIL zero_chal_end done=%b busy=%b launches=%0d pulses=%0d exp 0 0 0 1",
               done, busy, launch_count - l0, done_count - d0);
    end
    run_case(16'h0000, 1, 1'b1, 3'b111, 0, 0, 1'b0, 1'b0);
    run_case(16'h00F0, 2, 1'b0, 3'b000, 0, 1, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid();
    int waited;
    @(negedge clk);
    seed = 16'h2468; num_chal = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (puf_in !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (waited >= 50) begin
      errors++; $display("FAIL launch_timeout waited=%0d required<50", waited);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({puf_in, busy, resp_valid, puf_reset, done} !== 5'b0 || challenge !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid_launch puf_in=%b busy=%b valid=%b puf_reset=%b done=%b challenge=%h exp all 0",
               puf_in, busy, resp_valid, puf_reset, done, challenge);
    end
    reset = 1'b0;
    @(negedge clk);
    run_case(16'h2468, 1, 1'b0, 3'b000, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_noisy();
    test_backpressure();
    test_edge_cases();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
